// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM
// states, byte-lane base masks and small decode helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Lane mask of an access before it is shifted to its byte offset.
    function automatic logic [3:0] base_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = MASK_BYTE;
            2'b01:   m = MASK_HALF;
            default: m = MASK_WORD;
        endcase
        return m;
    endfunction

    // Unsigned widths exist only for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = ~we;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the two captured words down to the access
// offset, truncates to the access width and sign/zero-extends.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [31:0] sh_s;

    // Right-justify the addressed bytes, then extend according to the width code.
    always_comb begin
        sh_s = 32'(data_i >> {off_i, 3'b000});
        case (funct3_i)
            F3_LB:   rdata_o = {{24{sh_s[7]}}, sh_s[7:0]};
            F3_LBU:  rdata_o = {24'h000000, sh_s[7:0]};
            F3_LH:   rdata_o = {{16{sh_s[15]}}, sh_s[15:0]};
            F3_LHU:  rdata_o = {16'h0000, sh_s[15:0]};
            F3_LW:   rdata_o = sh_s;
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a combinational-read, byte-strobed
// data memory. One request at a time: IDLE -> ACC0 [-> ACC1] -> RESP.
// Faulting requests go IDLE -> RESP without touching memory.
// Build option: define LSU_MISALIGN_SPLIT_EN to execute word-crossing
// half/word accesses as two memory cycles; otherwise misaligned
// half/word accesses fault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int Depth = 128,
    parameter int Width = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [Width-1:0]         req_wdata,
    output logic                     rsp_valid,
    output logic [Width-1:0]         rsp_rdata,
    output logic                     rsp_err,
    output logic                     mem_we0,
    output logic [$clog2(Depth)-1:0] mem_wr_addr0,
    output logic [$clog2(Depth)-1:0] mem_rd_addr0,
    output logic [Width-1:0]         mem_wr_din0,
    output logic [3:0]               mem_wr_strb,
    output logic [3:0]               mem_rd_strb,
    input  logic [Width-1:0]         mem_rd_dout0
);

    localparam int          AW      = $clog2(Depth);
    localparam logic [31:0] DEPTH_W = 32'(Depth);

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [AW-1:0]   widx_q, widx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic            split_q, split_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     hi_q, hi_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;

    logic [31:0]     req_idx_s;
    logic            req_misalign_s;
    logic            req_split_s;
    logic            req_oob_s;
    logic            req_err_s;
    logic [7:0]      acc_mask8_s;
    logic [63:0]     wdata_sh_s;
    logic [31:0]     align_rdata_s;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]      req_mask8_s;
`endif

    // Classify the incoming request: alignment, two-word split and range faults.
    always_comb begin
        req_idx_s = {2'b00, req_addr[31:2]};
`ifdef LSU_MISALIGN_SPLIT_EN
        req_mask8_s    = {4'b0000, base_mask(req_funct3)} << req_addr[1:0];
        req_split_s    = |req_mask8_s[7:4];
        req_misalign_s = 1'b0;
`else
        req_split_s = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_misalign_s = req_addr[0];
            2'b10:   req_misalign_s = (req_addr[1:0] != 2'b00);
            default: req_misalign_s = 1'b0;
        endcase
`endif
        // The second word of a split must also exist, so no half-store can happen.
        req_oob_s = (req_idx_s >= DEPTH_W) ||
                    (req_split_s && ((req_idx_s + 32'd1) >= DEPTH_W));
        req_err_s = ~f3_legal(req_funct3, req_we) || req_misalign_s || req_oob_s;
    end

    // Sequencing and capture of the request and of the load words.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        widx_d   = widx_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        split_d  = split_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    widx_d   = req_addr[AW+1:2];
                    wdata_d  = req_wdata;
                    err_d    = req_err_s;
                    split_d  = req_split_s;
                    lo_d     = 32'h0000_0000;
                    hi_d     = 32'h0000_0000;
                    if (req_err_s) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACC0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (!we_q) begin
                    lo_d = mem_rd_dout0;
                end else begin
                    lo_d = lo_q;
                end
                if (split_q) begin
                    state_d = ST_ACC1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_ACC1: begin
                if (!we_q) begin
                    hi_d = mem_rd_dout0;
                end else begin
                    hi_d = hi_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    lsu_load_align u_align (
        .data_i   ({hi_d, lo_d}),
        .off_i    (off_d),
        .funct3_i (funct3_d),
        .rdata_o  (align_rdata_s)
    );

    // Next values of the registered handshake and response outputs.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = rsp_valid_d && err_d;
        if (rsp_valid_d && !err_d && !we_d) begin
            rsp_rdata_d = align_rdata_s;
        end else begin
            rsp_rdata_d = 32'h0000_0000;
        end
    end

    // Memory port drive: only the two access states touch memory.
    always_comb begin
        acc_mask8_s  = {4'b0000, base_mask(funct3_q)} << off_q;
        wdata_sh_s   = {32'h0000_0000, wdata_q} << {off_q, 3'b000};
        mem_we0      = 1'b0;
        mem_wr_addr0 = '0;
        mem_rd_addr0 = '0;
        mem_wr_din0  = 32'h0000_0000;
        mem_wr_strb  = 4'b0000;
        mem_rd_strb  = 4'b0000;
        case (state_q)
            ST_ACC0: begin
                mem_wr_addr0 = widx_q;
                mem_rd_addr0 = widx_q;
                if (we_q) begin
                    mem_we0     = 1'b1;
                    mem_wr_strb = acc_mask8_s[3:0];
                    mem_wr_din0 = wdata_sh_s[31:0];
                end else begin
                    mem_rd_strb = acc_mask8_s[3:0];
                end
            end
            ST_ACC1: begin
                mem_wr_addr0 = widx_q + AW'(1);
                mem_rd_addr0 = widx_q + AW'(1);
                if (we_q) begin
                    mem_we0     = 1'b1;
                    mem_wr_strb = acc_mask8_s[7:4];
                    mem_wr_din0 = wdata_sh_s[63:32];
                end else begin
                    mem_rd_strb = acc_mask8_s[7:4];
                end
            end
            default: begin
                mem_we0 = 1'b0;
            end
        endcase
    end

    // State, captured request and registered outputs; reset aborts any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            widx_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            err_q       <= 1'b0;
            split_q     <= 1'b0;
            lo_q        <= 32'h0000_0000;
            hi_q        <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            widx_q      <= widx_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            split_q     <= split_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
